// File: rtl/apb_uart_regif_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_uart_regif_pkg
// Description : Shared definitions for the UART APB register front-end:
//               register indices, access-type table, reset values and the
//               transfer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_uart_regif_pkg;

    // Number of mapped register slots; any index at or above this is unmapped
    localparam int unsigned NUM_REGS = 10;

    // Register indices (byte address divided by the register stride)
    localparam logic [3:0] IDX_TDR = 4'd0;
    localparam logic [3:0] IDX_RDR = 4'd1;
    localparam logic [3:0] IDX_LCR = 4'd2;
    localparam logic [3:0] IDX_OCR = 4'd3;
    localparam logic [3:0] IDX_LSR = 4'd4;
    localparam logic [3:0] IDX_FCR = 4'd5;
    localparam logic [3:0] IDX_MSR = 4'd6;
    localparam logic [3:0] IDX_MCR = 4'd7;
    localparam logic [3:0] IDX_IER = 4'd8;
    localparam logic [3:0] IDX_IIR = 4'd9;

    // Reset values of the RW configuration registers (truncated to DATA_W)
    localparam logic [31:0] LCR_RST = 32'h0000_0003;
    localparam logic [31:0] OCR_RST = 32'h0000_0000;
    localparam logic [31:0] FCR_RST = 32'h0000_0000;
    localparam logic [31:0] MCR_RST = 32'h0000_0000;
    localparam logic [31:0] IER_RST = 32'h0000_0000;

    // Access type of a register slot
    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_RW   = 2'd1,
        ACC_RO   = 2'd2,
        ACC_WO   = 2'd3
    } acc_t;

    // Transfer state of the APB slave
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // Access-type lookup; slots 10..15 report ACC_NONE
    function automatic acc_t reg_access(input logic [3:0] idx);
        acc_t acc;
        case (idx)
            IDX_TDR:                                     acc = ACC_WO;
            IDX_RDR, IDX_LSR, IDX_MSR, IDX_IIR:          acc = ACC_RO;
            IDX_LCR, IDX_OCR, IDX_FCR, IDX_MCR, IDX_IER: acc = ACC_RW;
            default:                                     acc = ACC_NONE;
        endcase
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_uart_regif_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_uart_regif_if
// Description : APB4 bus bundle between the interconnect (master) and the
//               UART register front-end (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_uart_regif_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    import apb_uart_regif_pkg::*;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W/8-1:0]   pstrb;
    logic [DATA_W-1:0]     pwdata;
    logic                  pready;
    logic                  pslverr;
    logic [DATA_W-1:0]     prdata;

    modport master (
        output psel, penable, pwrite, paddr, pstrb, pwdata,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pstrb, pwdata,
        output pready, pslverr, prdata
    );

endinterface
`default_nettype wire

// File: rtl/apb_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : apb_wait_ctrl
// Description : APB transfer sequencer. Tracks IDLE/ACCESS/WAIT, inserts
//               WAIT_STATES pready-low cycles, produces pready, pslverr and a
//               one-cycle commit strobe for error-free completions.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_ctrl
    import apb_uart_regif_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic clk,
    input  logic preset_n,
    input  logic psel,
    input  logic penable,
    input  logic err,
    output logic setup,
    output logic pready,
    output logic pslverr,
    output logic commit
);

    localparam logic [3:0] c_wait = 4'(WAIT_STATES);

    state_t     r_state;
    logic       r_pready;
    logic [3:0] r_cnt;

    // Transfer sequencing: capture on SETUP, count wait cycles, finish or abort
    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            r_state  <= IDLE;
            r_pready <= 1'b0;
            r_cnt    <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (psel && !penable) begin
                        r_state  <= ACCESS;
                        r_pready <= (c_wait == 4'd0);
                        r_cnt    <= c_wait;
                    end
                end
                ACCESS, WAIT: begin
                    if (!psel) begin
                        // Master dropped the transfer: abandon without effect
                        r_state  <= IDLE;
                        r_pready <= 1'b0;
                    end else if (r_pready) begin
                        if (penable) begin
                            r_state  <= IDLE;
                            r_pready <= 1'b0;
                        end
                    end else begin
                        r_state <= WAIT;
                        r_cnt   <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_pready <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_pready <= 1'b0;
                end
            endcase
        end
    end

    assign setup   = (r_state == IDLE) && psel && !penable;
    assign pready  = r_pready;
    // Error is evaluated live so FIFO status is taken at the completion edge
    assign pslverr = r_pready && err;
    assign commit  = r_pready && psel && penable && !err;

endmodule
`default_nettype wire

// File: rtl/apb_uart_regif.sv
`default_nettype none
// ============================================================================
// Module      : apb_uart_regif
// Description : APB4 slave front-end of the UART. Decodes the register map,
//               merges byte-strobed writes into the config registers, turns
//               TDR writes / RDR reads into FIFO push / pop strobes and
//               reports protocol/address errors through pslverr.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_uart_regif
    import apb_uart_regif_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic               clk,
    input  logic               preset_n,
    apb_uart_regif_if.slave    apb,
    output logic [DATA_W-1:0]  tx_data_o,
    output logic               tx_push_o,
    input  logic               tx_full_i,
    input  logic [DATA_W-1:0]  rx_data_i,
    output logic               rx_pop_o,
    input  logic               rx_empty_i,
    output logic [DATA_W-1:0]  lcr_o,
    output logic [DATA_W-1:0]  ocr_o,
    output logic [DATA_W-1:0]  fcr_o,
    output logic [DATA_W-1:0]  mcr_o,
    output logic [DATA_W-1:0]  ier_o,
    input  logic [DATA_W-1:0]  lsr_i,
    input  logic [DATA_W-1:0]  msr_i,
    input  logic [DATA_W-1:0]  iir_i
);

    localparam int c_lanes = DATA_W / 8;
    localparam int c_lsb   = $clog2(c_lanes);

    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_lcr, r_ocr, r_fcr, r_mcr, r_ier, r_tx_data;
    logic              r_tx_push, r_rx_pop;

    logic              w_setup, w_pready, w_pslverr, w_commit;
    logic [ADDR_W-1:0] w_idx;
    logic [3:0]        w_idx4;
    logic              w_mapped, w_misaligned, w_err;
    acc_t              w_acc;
    logic              w_wr_commit, w_rd_commit;
    logic [DATA_W-1:0] w_rdata;

    // Byte-lane merge of write data into an existing register value
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0]  cur,
        input logic [DATA_W-1:0]  wdata,
        input logic [c_lanes-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = cur;
        for (int b = 0; b < c_lanes; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        return res;
    endfunction

    apb_wait_ctrl #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_ctrl (
        .clk      (clk),
        .preset_n (preset_n),
        .psel     (apb.psel),
        .penable  (apb.penable),
        .err      (w_err),
        .setup    (w_setup),
        .pready   (w_pready),
        .pslverr  (w_pslverr),
        .commit   (w_commit)
    );

    // Address and direction are frozen at SETUP; later bus changes are ignored
    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            r_addr  <= '0;
            r_write <= 1'b0;
        end else if (w_setup) begin
            r_addr  <= apb.paddr;
            r_write <= apb.pwrite;
        end
    end

    // Decode of the captured address
    assign w_idx    = r_addr >> c_lsb;
    assign w_idx4   = w_idx[3:0];
    assign w_mapped = (w_idx < ADDR_W'(NUM_REGS));
    assign w_acc    = reg_access(w_idx4);

    generate
        if (c_lsb > 0) begin : g_align
            assign w_misaligned = |r_addr[c_lsb-1:0];
        end else begin : g_no_align
            assign w_misaligned = 1'b0;
        end
    endgenerate

    assign w_err = !w_mapped
                || w_misaligned
                || ( r_write && (w_acc == ACC_RO))
                || (!r_write && (w_acc == ACC_WO))
                || ( r_write && (w_idx4 == IDX_TDR) && tx_full_i)
                || (!r_write && (w_idx4 == IDX_RDR) && rx_empty_i);

    assign w_wr_commit = w_commit &&  r_write;
    assign w_rd_commit = w_commit && !r_write;

    // Config register updates with per-lane strobes
    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            r_lcr <= DATA_W'(LCR_RST);
            r_ocr <= DATA_W'(OCR_RST);
            r_fcr <= DATA_W'(FCR_RST);
            r_mcr <= DATA_W'(MCR_RST);
            r_ier <= DATA_W'(IER_RST);
        end else if (w_wr_commit) begin
            case (w_idx4)
                IDX_LCR: r_lcr <= merge_lanes(r_lcr, apb.pwdata, apb.pstrb);
                IDX_OCR: r_ocr <= merge_lanes(r_ocr, apb.pwdata, apb.pstrb);
                IDX_FCR: r_fcr <= merge_lanes(r_fcr, apb.pwdata, apb.pstrb);
                IDX_MCR: r_mcr <= merge_lanes(r_mcr, apb.pwdata, apb.pstrb);
                IDX_IER: r_ier <= merge_lanes(r_ier, apb.pwdata, apb.pstrb);
                default: ;
            endcase
        end
    end

    // FIFO side: TDR write loads data and pushes, RDR read pops, one cycle each
    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            r_tx_data <= '0;
            r_tx_push <= 1'b0;
            r_rx_pop  <= 1'b0;
        end else begin
            r_tx_push <= w_wr_commit && (w_idx4 == IDX_TDR);
            r_rx_pop  <= w_rd_commit && (w_idx4 == IDX_RDR);
            if (w_wr_commit && (w_idx4 == IDX_TDR)) begin
                r_tx_data <= apb.pwdata;
            end
        end
    end

    // Read mux; status inputs are passed through live
    always_comb begin
        w_rdata = '0;
        case (w_idx4)
            IDX_RDR: w_rdata = rx_data_i;
            IDX_LCR: w_rdata = r_lcr;
            IDX_OCR: w_rdata = r_ocr;
            IDX_LSR: w_rdata = lsr_i;
            IDX_FCR: w_rdata = r_fcr;
            IDX_MSR: w_rdata = msr_i;
            IDX_MCR: w_rdata = r_mcr;
            IDX_IER: w_rdata = r_ier;
            IDX_IIR: w_rdata = iir_i;
            default: w_rdata = '0;
        endcase
    end

    assign apb.pready  = w_pready;
    assign apb.pslverr = w_pslverr;
    assign apb.prdata  = (w_pready && !r_write && !w_err) ? w_rdata : '0;

    assign tx_data_o = r_tx_data;
    assign tx_push_o = r_tx_push;
    assign rx_pop_o  = r_rx_pop;
    assign lcr_o     = r_lcr;
    assign ocr_o     = r_ocr;
    assign fcr_o     = r_fcr;
    assign mcr_o     = r_mcr;
    assign ier_o     = r_ier;

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_regif.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_uart_regif
// Description : Self-checking bench for apb_uart_regif (WAIT_STATES=2):
//               directed scenarios followed by random APB traffic compared
//               against a register-map reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_uart_regif;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int WS     = 2;

    logic clk = 1'b0;
    logic preset_n = 1'b0;
    always #5 clk = ~clk;

    apb_uart_regif_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic [31:0] tx_data_o, rx_data_i, lcr_o, ocr_o, fcr_o, mcr_o, ier_o;
    logic [31:0] lsr_i, msr_i, iir_i;
    logic        tx_push_o, tx_full_i, rx_pop_o, rx_empty_i;

    apb_uart_regif #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WAIT_STATES (WS)
    ) dut (
        .clk        (clk),
        .preset_n   (preset_n),
        .apb        (bus),
        .tx_data_o  (tx_data_o),
        .tx_push_o  (tx_push_o),
        .tx_full_i  (tx_full_i),
        .rx_data_i  (rx_data_i),
        .rx_pop_o   (rx_pop_o),
        .rx_empty_i (rx_empty_i),
        .lcr_o      (lcr_o),
        .ocr_o      (ocr_o),
        .fcr_o      (fcr_o),
        .mcr_o      (mcr_o),
        .ier_o      (ier_o),
        .lsr_i      (lsr_i),
        .msr_i      (msr_i),
        .iir_i      (iir_i)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: register array indexed by register number
    logic [31:0] m_reg [16];
    logic [31:0] m_tx;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
        m_reg[2] = 32'h3;
        m_tx     = 32'h0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic check_regs();
        check("lcr_o", lcr_o, m_reg[2]);
        check("ocr_o", ocr_o, m_reg[3]);
        check("fcr_o", fcr_o, m_reg[5]);
        check("mcr_o", mcr_o, m_reg[7]);
        check("ier_o", ier_o, m_reg[8]);
        check("tx_data_o", tx_data_o, m_tx);
    endtask

    // Results of the last transfer
    int          t_edges;
    logic [31:0] t_rdata;
    logic        t_err, t_push, t_pop;

    // One APB transfer; called and returns at a falling edge
    task automatic do_xfer(input bit wr, input logic [11:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit scramble);
        int guard;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = data;
        bus.pstrb   = strb;
        t_edges     = 0;
        @(posedge clk); t_edges++;
        @(negedge clk);
        bus.penable = 1'b1;
        if (scramble) begin
            bus.paddr  = 12'($urandom);
            bus.pwrite = ~wr;
        end
        guard = 0;
        while (bus.pready !== 1'b1 && guard < 40) begin
            @(posedge clk); t_edges++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) check("pready_timeout", {31'b0, bus.pready}, 32'h1);
        t_rdata = bus.prdata;
        t_err   = bus.pslverr;
        @(posedge clk); t_edges++;
        @(negedge clk);
        t_push = tx_push_o;
        t_pop  = rx_pop_o;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    // Transfer plus comparison against the model
    task automatic run(input bit wr, input logic [11:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input bit scramble);
        int          idx;
        bit          mis, mapped, ro, wo, e_err;
        logic [31:0] e_rdata;
        idx    = int'(addr) / 4;
        mis    = (addr % 4) != 0;
        mapped = idx < 10;
        ro     = (idx == 1) || (idx == 4) || (idx == 6) || (idx == 9);
        wo     = (idx == 0);
        e_err  = !mapped || mis || (wr && ro) || (!wr && wo)
              || (wr && idx == 0 && tx_full_i) || (!wr && idx == 1 && rx_empty_i);
        if (e_err)          e_rdata = 32'h0;
        else if (idx == 1)  e_rdata = rx_data_i;
        else if (idx == 4)  e_rdata = lsr_i;
        else if (idx == 6)  e_rdata = msr_i;
        else if (idx == 9)  e_rdata = iir_i;
        else                e_rdata = m_reg[idx];

        do_xfer(wr, addr, data, strb, scramble);

        check("latency", t_edges, 2 + WS);
        check("pslverr", {31'b0, t_err}, {31'b0, e_err});
        if (!wr) check("prdata", t_rdata, e_rdata);
        check("tx_push", {31'b0, t_push}, {31'b0, wr && idx == 0 && !e_err});
        check("rx_pop",  {31'b0, t_pop},  {31'b0, !wr && idx == 1 && !e_err});
        if (wr && !e_err) begin
            if (idx == 0) m_tx = data;
            else          m_reg[idx] = merge(m_reg[idx], data, strb);
        end
        check_regs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
        tx_full_i = 1'b0; rx_empty_i = 1'b1; rx_data_i = 32'h0;
        lsr_i = 32'h0000_0060; msr_i = 32'h0000_00B0; iir_i = 32'h0000_0001;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pready",  {31'b0, bus.pready},  32'h0);
        check("rst_pslverr", {31'b0, bus.pslverr}, 32'h0);
        check("rst_prdata",  bus.prdata, 32'h0);
        check("rst_push",    {31'b0, tx_push_o}, 32'h0);
        check("rst_pop",     {31'b0, rx_pop_o},  32'h0);
        check_regs();
        preset_n = 1'b1;
        @(negedge clk);

        // Directed: LCR write with full strobes, MCR partial strobes
        run(1'b1, 12'h008, 32'h0000_001B, 4'hF, 1'b0);
        run(1'b1, 12'h01C, 32'hAABB_CCDD, 4'h5, 1'b0);
        run(1'b0, 12'h01C, 32'h0, 4'h0, 1'b1);
        // TDR writes: accepted, then refused while full
        tx_full_i = 1'b0;
        run(1'b1, 12'h000, 32'h0000_0041, 4'h0, 1'b0);
        tx_full_i = 1'b1;
        run(1'b1, 12'h000, 32'h0000_0099, 4'hF, 1'b0);
        tx_full_i = 1'b0;
        // RDR reads: data present, then empty
        rx_data_i = 32'h0000_005A; rx_empty_i = 1'b0;
        run(1'b0, 12'h004, 32'h0, 4'h0, 1'b0);
        rx_empty_i = 1'b1;
        run(1'b0, 12'h004, 32'h0, 4'h0, 1'b0);
        // Errors: misaligned, unmapped, RO write, TDR read; pstrb=0 no-op
        run(1'b1, 12'h002, 32'hFFFF_FFFF, 4'hF, 1'b0);
        run(1'b1, 12'h040, 32'hFFFF_FFFF, 4'hF, 1'b0);
        run(1'b1, 12'h010, 32'hFFFF_FFFF, 4'hF, 1'b0);
        run(1'b0, 12'h000, 32'h0, 4'h0, 1'b0);
        run(1'b1, 12'h014, 32'h1234_5678, 4'h0, 1'b0);
        run(1'b0, 12'h010, 32'h0, 4'h0, 1'b0);

        // Random traffic, back-to-back with occasional idle gaps
        for (int n = 0; n < 150; n++) begin
            int          r;
            logic [11:0] addr;
            r = int'($urandom_range(0, 15));
            if (r < 12)      addr = 12'(r * 4);
            else if (r < 14) addr = 12'($urandom_range(0, 11) * 4 + $urandom_range(1, 3));
            else             addr = 12'($urandom) & 12'hFFC;
            tx_full_i  = ($urandom % 4) == 0;
            rx_empty_i = ($urandom % 4) == 0;
            rx_data_i  = $urandom;
            lsr_i      = $urandom;
            msr_i      = $urandom;
            iir_i      = $urandom;
            run(1'($urandom % 2), addr, $urandom, 4'($urandom), 1'($urandom % 2));
            if (($urandom % 4) == 0) begin
                @(negedge clk);
                check("push_idle",   {31'b0, tx_push_o},  32'h0);
                check("pop_idle",    {31'b0, rx_pop_o},   32'h0);
                check("pready_idle", {31'b0, bus.pready}, 32'h0);
            end
        end

        // Abort: drop psel while waiting
        tx_full_i = 1'b0;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 12'h008; bus.pwdata = 32'hFFFF_FFFF; bus.pstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        bus.penable = 1'b1;
        check("abort_access_pready", {31'b0, bus.pready}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        bus.psel = 1'b0; bus.penable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_pready", {31'b0, bus.pready}, 32'h0);
        end
        check_regs();
        run(1'b1, 12'h008, 32'h0000_00FF, 4'hF, 1'b0);

        // Reset during ACCESS of a TDR write
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 12'h000; bus.pwdata = 32'h0000_0077; bus.pstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        bus.penable = 1'b1;
        preset_n = 1'b0;
        #1;
        model_reset();
        check("rst_mid_pready", {31'b0, bus.pready}, 32'h0);
        check_regs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_push", {31'b0, tx_push_o}, 32'h0);
            check("rst_mid_pop",  {31'b0, rx_pop_o},  32'h0);
        end
        bus.psel = 1'b0; bus.penable = 1'b0;
        preset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("post_rst_push", {31'b0, tx_push_o}, 32'h0);
            check("post_rst_pop",  {31'b0, rx_pop_o},  32'h0);
        end
        check_regs();
        run(1'b1, 12'h00C, 32'h0000_1234, 4'h3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_uart_regif.md
Name: apb_uart_regif

Overview:
Parametrised APB4 slave front-end for the UART: decodes APB transfers into the UART register map and inserts programmable wait states. Merges byte-strobe writes into the config registers and flags protocol and address errors via pslverr. Converts TDR writes into TX-FIFO push strobes and RDR reads into RX-FIFO pop strobes. Sits between the APB interconnect and the UART core/FIFOs.

Parameters:
ADDR_W, 12, paddr width; only bits [ADDR_W-1:0] are decoded.
DATA_W, 32, bus/register width; legal values 8, 16, 32. Register stride is DATA_W/8 bytes.
WAIT_STATES, 0, extra pready-low cycles inserted in ACCESS (0..15).

Ports:
clk  in  1  clock
preset_n  in  1  asynchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  1=write
paddr  in  ADDR_W  byte address
pstrb  in  DATA_W/8  write byte strobes
pwdata  in  DATA_W  write data
pready  out  1  transfer complete
pslverr  out  1  error, valid only while pready=1
prdata  out  DATA_W  read data, valid only while pready=1, else 0
tx_data_o  out  DATA_W  data for TX FIFO
tx_push_o  out  1  one-cycle TX FIFO push
tx_full_i  in  1  TX FIFO full
rx_data_i  in  DATA_W  RX FIFO head
rx_pop_o  out  1  one-cycle RX FIFO pop
rx_empty_i  in  1  RX FIFO empty
lcr_o, ocr_o, fcr_o, mcr_o, ier_o  out  DATA_W each  RW config registers
lsr_i, msr_i, iir_i  in  DATA_W each  RO status from core

Behaviour:
- Register map (index = paddr/(DATA_W/8)): 0 TDR (WO), 1 RDR (RO), 2 LCR, 3 OCR, 4 LSR (RO), 5 FCR, 6 MSR (RO), 7 MCR, 8 IER, 9 IIR (RO). Indices >=10 are unmapped.
- Reset values: lcr_o=0x03; ocr_o, fcr_o, mcr_o, ier_o, tx_data_o = 0; pready, pslverr, tx_push_o, rx_pop_o, prdata = 0; FSM = IDLE.
- FSM states: IDLE, ACCESS, WAIT.
  - IDLE -> ACCESS on psel & !penable (SETUP phase). Address and control are captured on that edge.
  - ACCESS: if WAIT_STATES=0, pready=1 in the first cycle of penable. Otherwise go to WAIT and hold pready=0 for WAIT_STATES cycles, then drive pready=1 for exactly one cycle.
  - After completion: return to IDLE. A back-to-back SETUP on the following cycle is accepted.
- Side effects commit only on the completion edge (psel & penable & pready). Latency for WAIT_STATES=N is 2+N cycles from SETUP.
- Error (pslverr=1 with pready, no side effect) on any of:
  - unmapped index;
  - misaligned paddr (low log2(DATA_W/8) bits nonzero);
  - write to an RO register;
  - read of TDR;
  - TDR write while tx_full_i=1, sampled at completion;
  - RDR read while rx_empty_i=1.
- RW write: byte lane i is updated only if pstrb[i]=1. pstrb=0 is a legal no-op with no error.
- TDR write: tx_data_o <= pwdata (strobes ignored); tx_push_o=1 for the cycle after completion.
- RDR read: prdata=rx_data_i during the pready cycle; rx_pop_o=1 for the cycle after completion.
- RO reads return the live input value in the pready cycle.
- psel deasserted while in ACCESS or WAIT: abort to IDLE, pready=0, no side effects.
- paddr/pwrite changing mid-transfer is ignored; the captured SETUP values are used.
- Reset mid-transfer: all outputs return to reset values immediately; no push or pop is emitted.

Decomposition:
- Package apb_uart_regif_pkg holds:
  - register index constants;
  - RO/RW/WO access-type table;
  - reset-value constants (LCR_RST=0x03);
  - state enum typedef (IDLE, ACCESS, WAIT).
- Sub-module apb_wait_ctrl holds the FSM plus wait counter. It outputs pready and a one-cycle commit strobe, takes an error input, and outputs pslverr.
- Decode, strobe merge and the read mux stay in apb_uart_regif.

Test Plan:
- WAIT_STATES=2: write LCR=0x0000001B, pstrb=0xF -> pready high exactly 4 cycles after SETUP, lcr_o=0x1B, pslverr=0.
- Write MCR=0xAABBCCDD with pstrb=0x5 from reset -> mcr_o=0x00BB00DD.
- TDR write 0x41 with tx_full_i=0 -> tx_push_o one cycle, tx_data_o=0x41. Repeat with tx_full_i=1 -> pslverr=1, no push.
- RDR read with rx_data_i=0x5A, rx_empty_i=0 -> prdata=0x5A, rx_pop_o one cycle. With rx_empty_i=1 -> pslverr=1, prdata=0, no pop.
- Error cases, each -> pslverr=1, registers unchanged:
  - paddr=0x02 (misaligned);
  - paddr=0x40 (unmapped);
  - write to LSR at 0x10.
- Abort and reset:
  - Drop psel during WAIT -> FSM back to IDLE, no register change.
  - Assert preset_n=0 during ACCESS -> lcr_o=0x03, no push or pop.
